// File: rtl/ram_sp_sr_sv.sv
// Single-port synchronous RAM: shared address, write enable and registered read-first output.
// Optional RAM_SP_CLEAR_ON_RESET_EN: zero every word, one per cycle, after reset deasserts.
module ram_sp_sr_sv #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] rd_q,
  input  logic                  we,
  input  logic                  oe
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = AW1'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic                  clearing_c;
  logic                  wr_en_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic [DATA_WIDTH-1:0] wr_data_c;

  assign in_range_c = ({1'b0, addr} < DEPTH_LIM);
  assign rd_idx_c   = IDX_W'(addr);

`ifdef RAM_SP_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  // Reset parks the sequencer at address 0 so a mid-clear reset restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign clearing_c = (state_q == ST_CLEAR);
  assign wr_en_c    = clearing_c | (we & in_range_c);
  assign wr_idx_c   = clearing_c ? clr_idx_q : rd_idx_c;
  assign wr_data_c  = clearing_c ? '0 : q;
`else
  assign clearing_c = 1'b0;
  assign wr_en_c    = we & in_range_c;
  assign wr_idx_c   = rd_idx_c;
  assign wr_data_c  = q;
`endif

  // Write port carries no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) begin
      mem[wr_idx_c] <= wr_data_c;
    end
  end

  // Registered read; non-blocking sampling gives read-first on a same-address write.
  always_ff @(posedge clk) begin
    if (reset || clearing_c) begin
      rd_q <= '0;
    end else if (oe) begin
      rd_q <= in_range_c ? mem[rd_idx_c] : '0;
    end
  end

endmodule

// File: tb/tb_ram_sp_sr_sv.sv
// Bench for ram_sp_sr_sv: directed steps plus random traffic against an array reference model.
module tb_ram_sp_sr_sv;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic          oe;
  logic [AW-1:0] addr;
  logic [DW-1:0] q;
  logic [DW-1:0] rd_q;

  int unsigned   cmp_cnt = 0;
  int unsigned   err_cnt = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_rd;
  int            clr_left = 0;
  logic [DW-1:0] wvals [4];

  always #5 clk = ~clk;

  ram_sp_sr_sv #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .q    (q),
    .rd_q (rd_q),
    .we   (we),
    .oe   (oe)
  );

  // One clock: drive on the falling edge, apply the memory rules at the rising edge, settle.
  task automatic cycle(input logic r, input logic w, input logic o,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    reset = r; we = w; oe = o; addr = a; q = d;
    @(posedge clk);
    if (r) begin
      exp_rd = '0;
`ifdef RAM_SP_CLEAR_ON_RESET_EN
      clr_left = DEPTH;
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
`endif
    end else if (clr_left > 0) begin
      exp_rd = '0;
      clr_left--;
    end else begin
      if (o) exp_rd = (int'(a) < int'(DEPTH)) ? model_mem[a] : '0;
      if (w && (int'(a) < int'(DEPTH))) model_mem[a] = d;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: rd_q=0x%02h expected 0x%02h", tag, obs, expv);
    end
  endtask

  // After a reset pulse the clearing window (if built in) must read back zero and ignore writes.
  task automatic post_reset_window();
`ifdef RAM_SP_CLEAR_ON_RESET_EN
    for (int i = 0; i < int'(DEPTH); i++) begin
      cycle(1'b0, 1'b1, 1'b1, AW'($urandom), DW'($urandom));
      check("clear_window", rd_q, 8'h00);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; oe = 1'b1; addr = '0; q = '0;
    wvals[0] = 8'h12; wvals[1] = 8'h34; wvals[2] = 8'h56; wvals[3] = 8'h78;

    // Reset with oe held high
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1, AW'(i), 8'h00);
      check("reset", rd_q, 8'h00);
    end
    post_reset_window();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, AW'(i + 9), 8'h00);
      check("reset_hold", rd_q, 8'h00);
    end

    // Write burst, then streaming read burst
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, AW'(i), wvals[i]);
      check("write_no_rd", rd_q, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, AW'(i), 8'h00);
      check("rd_burst", rd_q, wvals[i]);
    end

    // Hold with changing address
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, AW'(i * 17 + 1), 8'hEE);
      check("hold", rd_q, 8'h78);
    end

    // Read-during-write is read-first
    cycle(1'b0, 1'b1, 1'b0, 8'd5, 8'hAA);
    cycle(1'b0, 1'b1, 1'b1, 8'd5, 8'h55);
    check("rdw_old", rd_q, 8'hAA);
    cycle(1'b0, 1'b0, 1'b1, 8'd5, 8'h00);
    check("rdw_new", rd_q, 8'h55);

    // Full address range, no aliasing between extremes
    cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hC3);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C);
    cycle(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
    check("top_addr", rd_q, 8'hC3);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    check("bot_addr", rd_q, 8'h3C);

    // Reset pulse: rd_q zeroed; memory kept unless the clear option is built in
    cycle(1'b0, 1'b1, 1'b0, 8'd7, 8'h99);
    cycle(1'b1, 1'b1, 1'b1, 8'd7, 8'h11);
    check("reset_pulse", rd_q, 8'h00);
    post_reset_window();
    cycle(1'b0, 1'b0, 1'b1, 8'd7, 8'h00);
`ifdef RAM_SP_CLEAR_ON_RESET_EN
    check("after_reset_a7", rd_q, 8'h00);
`else
    check("after_reset_a7", rd_q, 8'h99);
`endif
    cycle(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
`ifdef RAM_SP_CLEAR_ON_RESET_EN
    check("after_reset_aff", rd_q, 8'h00);
`else
    check("after_reset_aff", rd_q, 8'hC3);
`endif

    // Fill every word so random reads never see undefined contents
    for (int i = 0; i < int'(DEPTH); i++) begin
      cycle(1'b0, 1'b1, 1'b0, AW'(i), DW'($urandom));
      check("fill_hold", rd_q, exp_rd);
    end

    // Random traffic, occasional reset, checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
            AW'($urandom), DW'($urandom));
      check("random", rd_q, exp_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ram_sp_sr_sv.md
Name: ram_sp_sr_sv

Overview:
Single-port synchronous RAM with one shared address bus, a write enable and a read (output) enable.
- Writes and reads both occur on the rising clock edge.
- Read data is registered, so it appears one cycle after the read is sampled.
- Used as a small scratch/buffer memory, e.g. behind a memcopy engine, with an external mux choosing between read and write addresses.

Parameters:
DATA_WIDTH, 8, width of each word and of the data ports
ADDR_WIDTH, 8, width of addr
DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
addr  in  ADDR_WIDTH  shared read/write address
q  in  DATA_WIDTH  write data
rd_q  out  DATA_WIDTH  registered read data
we  in  1  write enable, sampled on rising clk
oe  in  1  read/output enable, sampled on rising clk

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset: when reset=1 at a rising edge, rd_q <= 0.
  - Memory contents are not affected by reset (unless the optional feature is enabled).
  - we and oe are ignored in that cycle.
- Write: when we=1 and reset=0 at a rising edge, mem[addr] <= q.
- Read: when oe=1 and reset=0 at a rising edge, rd_q <= mem[addr].
  - Latency is 1 cycle: rd_q is valid after the same edge that sampled oe.
- Hold: when oe=0, rd_q keeps its last value. There is no tri-state and no zeroing.
- Read-during-write (we=1, oe=1, same edge):
  - read-first; rd_q gets the old mem[addr];
  - the write still completes;
  - the next read of that address returns q.
- Address range:
  - if addr >= DEPTH, a write is dropped;
  - a read returns 0 into rd_q.
  - With default parameters, all 256 addresses are valid.
- Address wrap: none internally; the caller sequences addresses.
- Power-up: memory contents are undefined (X in simulation). rd_q is undefined until the first reset or read.
- Back-to-back: a read and a write may be issued every cycle with no gaps. Consecutive oe cycles with a changing addr stream one word per cycle.
- Inference: the memory must infer as block RAM, with a single registered read port and no asynchronous read path.

Optional Feature:
- Macro: RAM_SP_CLEAR_ON_RESET_EN.
- Defined:
  - after reset deasserts, an internal clear sequencer writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles);
  - we and oe are ignored and rd_q is held at 0 while clearing;
  - reset asserted mid-clear restarts the sequence from address 0 on deassertion.
- Not defined: no sequencer; reset touches only rd_q; memory keeps its contents across reset.

Test Plan:
- Reset: assert reset 2 cycles with oe=1 -> rd_q=0x00; after release with oe=0, rd_q stays 0x00.
- Write then read:
  - we=1 at addr 0..3 with q=0x12,0x34,0x56,0x78 on consecutive cycles;
  - then oe=1 at addr 0..3 -> rd_q = 0x12,0x34,0x56,0x78, each one cycle after its address.
- Hold: after the read burst, drop oe with addr changing -> rd_q stays 0x78.
- Read-during-write:
  - mem[5]=0xAA, then we=1, oe=1, addr=5, q=0x55 -> rd_q=0xAA;
  - next cycle oe=1, we=0, addr=5 -> rd_q=0x55.
- Full range: write addr=0xFF with q=0xC3, write addr=0x00 with q=0x3C -> reads return 0xC3 and 0x3C, with no aliasing.
- Optional feature (macro defined):
  - write 0x99 at addr 7, pulse reset for 1 cycle, wait DEPTH cycles;
  - read addr 7 -> 0x00;
  - reads issued during the clear window return 0x00 and are ignored.
